// File: rtl/mem_burst_reader_if.sv
// Bundles the burst request, memory read port, output stream and status signals of mem_burst_reader.
// With MEM_BURST_READER_CHECKSUM_EN defined, the bundle also carries the running checksum.
interface mem_burst_reader_if #(
   parameter int unsigned SIZE  = 16,
   parameter int unsigned DEPTH = 64
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic            start;
   logic [AW-1:0]   base_addr;
   logic [AW:0]     count;
   logic [AW-1:0]   raddr;
   logic [SIZE-1:0] read_data;
   logic [SIZE-1:0] out_data;
   logic            out_valid;
   logic            out_ready;
   logic            busy;
   logic            done;
`ifdef MEM_BURST_READER_CHECKSUM_EN
   logic [SIZE-1:0] checksum;

   modport master (
      output start, base_addr, count, read_data, out_ready,
      input  raddr, out_data, out_valid, busy, done, checksum
   );
   modport slave (
      input  start, base_addr, count, read_data, out_ready,
      output raddr, out_data, out_valid, busy, done, checksum
   );
`else
   modport master (
      output start, base_addr, count, read_data, out_ready,
      input  raddr, out_data, out_valid, busy, done
   );
   modport slave (
      input  start, base_addr, count, read_data, out_ready,
      output raddr, out_data, out_valid, busy, done
   );
`endif
endinterface

// File: rtl/mem_burst_reader.sv
// Reads a burst of words from a combinational-read memory and streams them out with valid/ready.
// Optional MEM_BURST_READER_CHECKSUM_EN adds a modulo-2^SIZE sum of all handed-off words.
module mem_burst_reader #(
   parameter int unsigned SIZE  = 16,
   parameter int unsigned DEPTH = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_burst_reader_if.slave    bus
);
   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   logic [AW:0]     remaining_q, remaining_d;
   logic [SIZE-1:0] out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            load_c;
   logic            hs_c;
   logic [AW-1:0]   raddr_next_c;
`ifdef MEM_BURST_READER_CHECKSUM_EN
   logic [SIZE-1:0] checksum_q, checksum_d;
`endif

   assign load_c       = !out_valid_q || bus.out_ready;
   assign hs_c         = out_valid_q && bus.out_ready;
   // Explicit wrap keeps non-power-of-two DEPTH correct.
   assign raddr_next_c = (raddr_q == AW'(DEPTH - 1)) ? '0 : raddr_q + AW'(1);

   // Next-state and datapath updates.
   always_comb begin
      state_d     = state_q;
      raddr_d     = raddr_q;
      remaining_d = remaining_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
`ifdef MEM_BURST_READER_CHECKSUM_EN
      checksum_d  = checksum_q;
      if (hs_c) begin
         checksum_d = checksum_q + out_data_q;
      end
`endif
      if (hs_c) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
`ifdef MEM_BURST_READER_CHECKSUM_EN
               checksum_d = '0;
`endif
               if (bus.count != '0) begin
                  raddr_d     = bus.base_addr;
                  remaining_d = bus.count;
                  state_d     = READ;
               end else begin
                  state_d = FINISH;
               end
            end
         end
         READ: begin
            // A load both retires any accepted word and refills the output register.
            if (load_c) begin
               out_data_d  = bus.read_data;
               out_valid_d = 1'b1;
               raddr_d     = raddr_next_c;
               remaining_d = remaining_q - (AW + 1)'(1);
               if (remaining_q == (AW + 1)'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (hs_c) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == FINISH);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         raddr_q     <= '0;
         remaining_q <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         raddr_q     <= raddr_d;
         remaining_q <= remaining_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

`ifdef MEM_BURST_READER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign bus.checksum = checksum_q;
`endif

   assign bus.raddr     = raddr_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader: bursts, address wrap, back-pressure, empty burst, mid-burst reset.
// The checksum scenario runs only when MEM_BURST_READER_CHECKSUM_EN is defined.
module tb_mem_burst_reader;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   logic [15:0] mem [64];

   mem_burst_reader_if #(.SIZE(16), .DEPTH(64)) bus ();

   mem_burst_reader #(.SIZE(16), .DEPTH(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.read_data = mem[bus.raddr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0]  pat;
      logic        prev_v;
      logic [15:0] prev_d;
      int          n_hs;
      logic        saw_done;

      errors = 0;
      checks = 0;
      for (int i = 0; i < 64; i++) mem[i] = 16'(i + 16'h100);

      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.count     = '0;
      bus.out_ready = 1'b1;
      step();
      step();
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      chk("rst_done",  32'(bus.done),      32'd0);
      chk("rst_raddr", 32'(bus.raddr),     32'd0);
      chk("rst_data",  32'(bus.out_data),  32'd0);
      rst = 1'b0;

      // Basic burst, with start held high while busy (must be ignored).
      bus.base_addr = 6'd4;
      bus.count     = 7'd3;
      bus.start     = 1'b1;
      step();
      bus.base_addr = 6'd40;
      chk("b1_busy",   32'(bus.busy),      32'd1);
      chk("b1_nvalid", 32'(bus.out_valid), 32'd0);
      chk("b1_raddr",  32'(bus.raddr),     32'd4);
      step();
      chk("b1_v0",     32'(bus.out_valid), 32'd1);
      chk("b1_d0",     32'(bus.out_data),  32'h104);
      step();
      chk("b1_d1",     32'(bus.out_data),  32'h105);
      step();
      chk("b1_d2",     32'(bus.out_data),  32'h106);
      chk("b1_nodone", 32'(bus.done),      32'd0);
      bus.start = 1'b0;
      step();
      chk("b1_done",   32'(bus.done),      32'd1);
      chk("b1_vlow",   32'(bus.out_valid), 32'd0);
      chk("b1_busyf",  32'(bus.busy),      32'd1);
      step();
      chk("b1_done0",  32'(bus.done),      32'd0);
      chk("b1_idle",   32'(bus.busy),      32'd0);
      step();
      chk("b1_noqueue", 32'(bus.busy),     32'd0);

      // Address wrap: 62,63,0,1.
      bus.base_addr = 6'd62;
      bus.count     = 7'd4;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      chk("w_a0", 32'(bus.raddr),    32'd62);
      step();
      chk("w_d0", 32'(bus.out_data), 32'h13E);
      chk("w_a1", 32'(bus.raddr),    32'd63);
      step();
      chk("w_d1", 32'(bus.out_data), 32'h13F);
      chk("w_a2", 32'(bus.raddr),    32'd0);
      step();
      chk("w_d2", 32'(bus.out_data), 32'h100);
      chk("w_a3", 32'(bus.raddr),    32'd1);
      step();
      chk("w_d3", 32'(bus.out_data), 32'h101);
      step();
      chk("w_done",  32'(bus.done),  32'd1);
      chk("w_hold",  32'(bus.raddr), 32'd2);
      step();

      // Back-pressure: five words from address 10 under a stalling out_ready.
      pat           = 6'b101001;
      bus.base_addr = 6'd10;
      bus.count     = 7'd5;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      n_hs      = 0;
      saw_done  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         bus.out_ready = (i < 6) ? pat[i] : 1'(i % 2);
         prev_v = bus.out_valid;
         prev_d = bus.out_data;
         step();
         if (prev_v && bus.out_ready) begin
            chk("bp_word", 32'(prev_d), 32'(16'h10A + 16'(n_hs)));
            n_hs++;
         end else if (prev_v) begin
            chk("bp_stable", 32'(bus.out_data),  32'(prev_d));
            chk("bp_vhold",  32'(bus.out_valid), 32'd1);
         end
         if (bus.done) begin
            saw_done = 1'b1;
            break;
         end
      end
      chk("bp_count", 32'(n_hs),     32'd5);
      chk("bp_done",  32'(saw_done), 32'd1);
      bus.out_ready = 1'b1;
      step();

      // Empty burst.
      bus.count = 7'd0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("z_busy",  32'(bus.busy),      32'd1);
      chk("z_done",  32'(bus.done),      32'd1);
      chk("z_valid", 32'(bus.out_valid), 32'd0);
      step();
      chk("z_busy0", 32'(bus.busy),      32'd0);
      chk("z_done0", 32'(bus.done),      32'd0);

      // Reset after two of six words, then a fresh single-word burst.
      bus.base_addr = 6'd20;
      bus.count     = 7'd6;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      chk("r_mid", 32'(bus.out_data), 32'h115);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("r_valid", 32'(bus.out_valid), 32'd0);
      chk("r_busy",  32'(bus.busy),      32'd0);
      chk("r_raddr", 32'(bus.raddr),     32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("r_nodone", 32'(bus.done),      32'd0);
         chk("r_quiet",  32'(bus.out_valid), 32'd0);
      end
      bus.base_addr = 6'd0;
      bus.count     = 7'd1;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      chk("r2_valid", 32'(bus.out_valid), 32'd1);
      chk("r2_data",  32'(bus.out_data),  32'h100);
      step();
      chk("r2_done",  32'(bus.done),      32'd1);
      chk("r2_vlow",  32'(bus.out_valid), 32'd0);
      step();
      chk("r2_idle",  32'(bus.busy),      32'd0);

`ifdef MEM_BURST_READER_CHECKSUM_EN
      mem[0] = 16'hFFFF;
      mem[1] = 16'h0002;
      mem[2] = 16'h0003;
      mem[3] = 16'h0004;
      bus.base_addr = 6'd0;
      bus.count     = 7'd4;
      bus.start     = 1'b1;
      step();
      bus.start = 1'b0;
      chk("cs_clear", 32'(bus.checksum), 32'd0);
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.done) begin
            saw_done = 1'b1;
            break;
         end
      end
      chk("cs_done", 32'(saw_done),     32'd1);
      chk("cs_sum",  32'(bus.checksum), 32'h0008);
      step();
      chk("cs_hold", 32'(bus.checksum), 32'h0008);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("cs_rst",  32'(bus.checksum), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
